// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the program counter, issues imem reads and drives the IF/ID register.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// FETCH  | normal operation; PC advances on ihit, honours stall/redirect
// HALT   | halt decoded; imem idle, PC and IF/ID frozen until reset
//
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   ihit, imemload     imem handshake and returned instruction word
//   imemREN, imemaddr  imem read enable and byte address (= PC)
//   stall              hazard unit: hold PC and IF/ID
//   redirect, redirect_addr  resolved control transfer and its target
//   halt               halt decoded downstream
//   ifid_instr, ifid_npc, ifid_valid  IF/ID pipeline register
//   halted             stage is in HALT
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Target is word-aligned; the wrong-path word in IF/ID is squashed.
          pc_d    = {redirect_addr[31:2], 2'b00};
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end else if (halt) begin
          state_d = S_HALT;
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; a word returned now is simply refetched later.
        end else if (ihit) begin
          pc_d    = pc_plus4;
          instr_d = imemload;
          npc_d   = pc_plus4;
          valid_d = 1'b1;
        end else begin
          // Bubble is all-zero (sll $0,$0,0) so decode treats it as a nop.
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_HALT: begin
        // IF/ID already holds a bubble from the halting edge; hold it all.
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imemaddr   = pc_q;
  assign imemREN    = (state_q == S_FETCH);
  assign halted     = (state_q == S_HALT);
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        CLK;
  logic        nRST, nRST_w;
  logic        ihit, stall, redirect, halt;
  logic [31:0] redirect_addr;
  logic [31:0] imemload, imemload_w;
  logic        imemREN, imemREN_w;
  logic [31:0] imemaddr, imemaddr_w;
  logic [31:0] ifid_instr, ifid_instr_w;
  logic [31:0] ifid_npc, ifid_npc_w;
  logic        ifid_valid, ifid_valid_w;
  logic        halted, halted_w;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries: {expected instr, expected npc}
  logic [63:0] sb_q[$];
  logic [31:0] m_pc;
  logic        m_halted;

  fetch_stage #(.PC_INIT(32'h00000000)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
    .halted(halted)
  );

  fetch_stage #(.PC_INIT(32'hFFFFFFFC)) u_wrap (
    .CLK(CLK), .nRST(nRST_w), .ihit(ihit), .imemload(imemload_w),
    .imemREN(imemREN_w), .imemaddr(imemaddr_w), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .ifid_instr(ifid_instr_w), .ifid_npc(ifid_npc_w), .ifid_valid(ifid_valid_w),
    .halted(halted_w)
  );

  // Instruction memory model: word at address A is A + 0x100.
  always_comb imemload   = imemaddr + 32'h100;
  always_comb imemload_w = imemaddr_w + 32'h100;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of inputs, updates the reference model / scoreboard,
  // and returns 1 time unit after the active edge.
  task automatic drive(input logic h, input logic s, input logic r,
                       input logic [31:0] ra, input logic hl);
    ihit = h; stall = s; redirect = r; redirect_addr = ra; halt = hl;
    if (!m_halted) begin
      if (r) m_pc = {ra[31:2], 2'b00};
      else if (hl) m_halted = 1'b1;
      else if (s) begin end
      else if (h) begin
        sb_q.push_back({m_pc + 32'h100, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    ihit = 0; stall = 0; redirect = 0; redirect_addr = 0; halt = 0;
    nRST = 1; nRST_w = 1;
    #1; nRST = 0; nRST_w = 0;
    #1;
    checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imemaddr, 32'h0); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren: got %b want 1", imemREN); end
    checks++; if ({ifid_instr, ifid_npc, ifid_valid} !== 65'h0) begin errors++; $display("FAIL reset_ifid: got %h %h %b want 0", ifid_instr, ifid_npc, ifid_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    @(negedge CLK); nRST = 1;
    m_pc = 32'h0; m_halted = 1'b0; sb_q.delete();
  endtask

  task automatic test_stream();
    logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++; if (imemaddr !== m_pc) begin errors++; $display("FAIL stream_addr: got %h want %h", imemaddr, m_pc); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b want 1", ifid_valid); end
      if (sb_q.size() == 0) begin errors++; checks++; $display("FAIL stream_sb: got empty want entry"); end
      else begin
        e = sb_q.pop_front();
        checks++; if ({ifid_instr, ifid_npc} !== e) begin errors++; $display("FAIL stream_data: got %h %h want %h %h", ifid_instr, ifid_npc, e[63:32], e[31:0]); end
      end
    end
  endtask

  task automatic test_ihit_low();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++; if (imemaddr !== 32'h8) begin errors++; $display("FAIL miss_addr: got %h want %h", imemaddr, 32'h8); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL miss_bubble: got %b %h want 0 0", ifid_valid, ifid_instr); end
    end
    drive(1, 0, 0, 0, 0);
    checks++; if (imemaddr !== 32'hC) begin errors++; $display("FAIL miss_next: got %h want %h", imemaddr, 32'hC); end
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, 32'h108, 32'hC} || {ifid_instr, ifid_npc} !== e) begin
      errors++; $display("FAIL miss_data: got %b %h %h want 1 00000108 0000000c", ifid_valid, ifid_instr, ifid_npc);
    end
    drive(1, 0, 0, 0, 0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
  endtask

  task automatic test_stall();
    logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0);
      checks++; if (imemaddr !== 32'h10) begin errors++; $display("FAIL stall_addr: got %h want %h", imemaddr, 32'h10); end
      checks++; if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, 32'h10C, 32'h10}) begin
        errors++; $display("FAIL stall_hold: got %b %h %h want 1 0000010c 00000010", ifid_valid, ifid_instr, ifid_npc);
      end
    end
    drive(1, 0, 0, 0, 0);
    checks++; if (imemaddr !== 32'h14) begin errors++; $display("FAIL stall_release: got %h want %h", imemaddr, 32'h14); end
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if ({ifid_instr, ifid_npc} !== e) begin errors++; $display("FAIL stall_data: got %h %h want %h %h", ifid_instr, ifid_npc, e[63:32], e[31:0]); end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    drive(1, 1, 1, 32'h43, 0);
    checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h want %h", imemaddr, 32'h40); end
    checks++; if ({ifid_valid, ifid_instr, ifid_npc} !== 65'h0) begin errors++; $display("FAIL redir_squash: got %b %h %h want 0", ifid_valid, ifid_instr, ifid_npc); end
    drive(1, 0, 1, 32'h1E, 1);
    checks++; if (halted !== 1'b0 || imemREN !== 1'b1) begin errors++; $display("FAIL redir_halt: got halted=%b ren=%b want 0 1", halted, imemREN); end
    checks++; if (imemaddr !== 32'h1C) begin errors++; $display("FAIL redir_addr2: got %h want %h", imemaddr, 32'h1C); end
    drive(1, 0, 0, 0, 0);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
    checks++; if ({ifid_instr, ifid_npc} !== e || ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_fetch: got %h %h %b want %h %h 1", ifid_instr, ifid_npc, ifid_valid, e[63:32], e[31:0]); end
  endtask

  task automatic test_halt();
    drive(0, 0, 0, 0, 1);
    checks++; if (halted !== 1'b1 || imemREN !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b ren=%b want 1 0", halted, imemREN); end
    checks++; if (ifid_valid !== 1'b0 || imemaddr !== 32'h20) begin errors++; $display("FAIL halt_state: got valid=%b addr=%h want 0 00000020", ifid_valid, imemaddr); end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h80 + 32'(i * 4), 1'($urandom_range(0, 1)));
      checks++; if (imemaddr !== 32'h20 || halted !== 1'b1 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
        errors++; $display("FAIL halt_hold: got addr=%h halted=%b valid=%b instr=%h want 00000020 1 0 0", imemaddr, halted, ifid_valid, ifid_instr);
      end
    end
    ihit = 0; stall = 0; redirect = 0; halt = 0;
    nRST = 0; #1;
    checks++; if (imemaddr !== 32'h0 || halted !== 1'b0 || imemREN !== 1'b1) begin
      errors++; $display("FAIL halt_reset: got addr=%h halted=%b ren=%b want 0 0 1", imemaddr, halted, imemREN);
    end
    @(negedge CLK); nRST = 1;
    m_pc = 32'h0; m_halted = 1'b0; sb_q.delete();
    drive(1, 0, 0, 0, 0);
    checks++; if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, 32'h100, 32'h4}) begin
      errors++; $display("FAIL halt_restart: got %b %h %h want 1 00000100 00000004", ifid_valid, ifid_instr, ifid_npc);
    end
  endtask

  task automatic test_wrap();
    nRST = 0;
    ihit = 0; stall = 0; redirect = 0; halt = 0;
    @(negedge CLK); nRST_w = 1;
    checks++; if (imemaddr_w !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_init: got %h want fffffffc", imemaddr_w); end
    ihit = 1;
    @(posedge CLK); #1;
    checks++; if (imemaddr_w !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", imemaddr_w); end
    checks++; if ({ifid_valid_w, ifid_instr_w, ifid_npc_w} !== {1'b1, 32'h000000FC, 32'h0}) begin
      errors++; $display("FAIL wrap_data: got %b %h %h want 1 000000fc 00000000", ifid_valid_w, ifid_instr_w, ifid_npc_w);
    end
    @(posedge CLK); #1;
    checks++; if ({ifid_instr_w, ifid_npc_w} !== {32'h100, 32'h4}) begin
      errors++; $display("FAIL wrap_next: got %h %h want 00000100 00000004", ifid_instr_w, ifid_npc_w);
    end
    ihit = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ihit_low();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
